// File: rtl/blob_lane_serializer.sv
// Width-converting elastic stage: buffers LANES*DW-bit beats in a small FIFO and
// serializes them one DW-bit lane per cycle, lane 0 first, carrying eop through.
module blob_lane_serializer #(
  parameter int LANES      = 8,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int SKID       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] blob_din,
  input  logic                blob_din_en,
  input  logic                blob_din_eop,
  output logic                blob_din_rdy,
  output logic [DW-1:0]       blob_dout,
  output logic                blob_dout_en,
  output logic                blob_dout_eop,
  input  logic                blob_dout_rdy,
  output logic                overflow
);

  localparam int BEAT_W = LANES * DW;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [FIFO_AW:0]  DEPTH_C   = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]  SKID_C    = SKID[FIFO_AW:0];
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  logic [BEAT_W:0]    r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;

  state_t             r_state,    w_state_nxt;
  logic [BEAT_W-1:0]  r_shift,    w_shift_nxt;
  logic               r_eop,      w_eop_nxt;
  logic [LANE_W-1:0]  r_lane,     w_lane_nxt;
  logic [DW-1:0]      r_dout,     w_dout_nxt;
  logic               r_dout_en,  w_dout_en_nxt;
  logic               r_dout_eop, w_dout_eop_nxt;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_nonempty;
  logic [BEAT_W:0]    w_head;
  logic [DW-1:0]      w_lane_word;

  assign w_full       = (r_count == DEPTH_C);
  assign w_nonempty   = (r_count != '0);
  assign w_push       = blob_din_en && !w_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_lane_word  = r_shift[int'(r_lane)*DW +: DW];
  // Conservative: ignores a pop that may happen on the same edge.
  assign blob_din_rdy = (DEPTH_C - r_count) > SKID_C;

  // NOTE: storage has no reset; validity is tracked by r_count, which is reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {blob_din_eop, blob_din};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (blob_din_en && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_eop      <= 1'b0;
      r_lane     <= '0;
      r_dout     <= '0;
      r_dout_en  <= 1'b0;
      r_dout_eop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_eop      <= w_eop_nxt;
      r_lane     <= w_lane_nxt;
      r_dout     <= w_dout_nxt;
      r_dout_en  <= w_dout_en_nxt;
      r_dout_eop <= w_dout_eop_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_eop_nxt      = r_eop;
    w_lane_nxt     = r_lane;
    w_dout_nxt     = r_dout;
    w_dout_en_nxt  = 1'b0;
    w_dout_eop_nxt = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty && blob_dout_rdy) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head[BEAT_W-1:0];
          w_eop_nxt     = w_head[BEAT_W];
          w_dout_nxt    = w_head[DW-1:0];
          w_dout_en_nxt = 1'b1;
          w_lane_nxt    = LANE_W'(1);
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (blob_dout_rdy) begin
          w_dout_nxt    = w_lane_word;
          w_dout_en_nxt = 1'b1;
          if (r_lane == LAST_LANE) begin
            w_dout_eop_nxt = r_eop;
            w_lane_nxt     = '0;
            // Next beat's lane 0 goes out on the following edge: no bubble.
            if (w_nonempty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_head[BEAT_W-1:0];
              w_eop_nxt   = w_head[BEAT_W];
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_lane_nxt = r_lane + LANE_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign blob_dout     = r_dout;
  assign blob_dout_en  = r_dout_en;
  assign blob_dout_eop = r_dout_eop;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_blob_lane_serializer.sv
// Directed self-checking bench for blob_lane_serializer: single beat, streaming,
// output stalls, FIFO fill/overflow, mid-operation reset and stray eop.
module tb_blob_lane_serializer;

  localparam int LANES = 8;
  localparam int DW    = 16;

  logic                clk;
  logic                rst;
  logic [LANES*DW-1:0] blob_din;
  logic                blob_din_en;
  logic                blob_din_eop;
  logic                blob_din_rdy;
  logic [DW-1:0]       blob_dout;
  logic                blob_dout_en;
  logic                blob_dout_eop;
  logic                blob_dout_rdy;
  logic                overflow;

  int n_tests = 0;
  int n_fail  = 0;

  blob_lane_serializer #(
    .LANES(LANES), .DW(DW), .FIFO_DEPTH(4), .FIFO_AW(2), .SKID(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blob_din     (blob_din),
    .blob_din_en  (blob_din_en),
    .blob_din_eop (blob_din_eop),
    .blob_din_rdy (blob_din_rdy),
    .blob_dout    (blob_dout),
    .blob_dout_en (blob_dout_en),
    .blob_dout_eop(blob_dout_eop),
    .blob_dout_rdy(blob_dout_rdy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*DW-1:0] mk_beat(input logic [DW-1:0] base);
    logic [LANES*DW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  // One beat with dout_rdy held high: lane i appears in cycle t+2+i.
  task automatic single_beat(input string tag, input logic [DW-1:0] base, input logic eop_in);
    blob_din     = mk_beat(base);
    blob_din_en  = 1'b1;
    blob_din_eop = eop_in;
    tick();
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    check({tag, "_count1"}, 32'(dut.r_count), 32'd1);
    tick();
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("%s_dout%0d", tag, i), 32'(blob_dout), 32'(base + DW'(i)));
      check($sformatf("%s_en%0d", tag, i), 32'(blob_dout_en), 32'd1);
      check($sformatf("%s_eop%0d", tag, i), 32'(blob_dout_eop), 32'((i == LANES-1) && eop_in));
      tick();
    end
    check({tag, "_en_after"}, 32'(blob_dout_en), 32'd0);
    check({tag, "_count_after"}, 32'(dut.r_count), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] exp_w;

    rst           = 1'b1;
    blob_din      = '0;
    blob_din_en   = 1'b0;
    blob_din_eop  = 1'b0;
    blob_dout_rdy = 1'b1;
    #1;
    check("rst_din_rdy_during", 32'(blob_din_rdy), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_dout", 32'(blob_dout), 32'd0);
    check("rst_en", 32'(blob_dout_en), 32'd0);
    check("rst_eop", 32'(blob_dout_eop), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_din_rdy", 32'(blob_din_rdy), 32'd1);

    // Test 1: single beat 0x0001..0x0008 with eop
    single_beat("t1", 16'h0001, 1'b1);

    // Test 2: four beats every 8 cycles -> 32 contiguous words, eop on last
    for (int c = 0; c < 34; c++) begin
      if ((c % 8 == 0) && (c < 32)) begin
        blob_din     = mk_beat(16'((c/8 + 1) * 256));
        blob_din_en  = 1'b1;
        blob_din_eop = (c == 24);
      end else begin
        blob_din_en  = 1'b0;
        blob_din_eop = 1'b0;
      end
      check($sformatf("t2_din_rdy_c%0d", c), 32'(blob_din_rdy), 32'd1);
      if (c >= 2) begin
        exp_w = 16'(((c-2)/8 + 1) * 256 + (c-2) % 8);
        check($sformatf("t2_dout_w%0d", c-2), 32'(blob_dout), 32'(exp_w));
        check($sformatf("t2_en_w%0d", c-2), 32'(blob_dout_en), 32'd1);
        check($sformatf("t2_eop_w%0d", c-2), 32'(blob_dout_eop), 32'(c == 33));
      end
      tick();
    end
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    check("t2_en_after", 32'(blob_dout_en), 32'd0);

    // Test 3: dout_rdy toggles 1/0 -> 8 words over 16 cycles, held while en=0
    blob_din     = mk_beat(16'h1000);
    blob_din_en  = 1'b1;
    blob_din_eop = 1'b1;
    tick();
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      blob_dout_rdy = (j % 2 == 0);
      if (j % 2 == 1) begin
        check($sformatf("t3_dout_j%0d", j), 32'(blob_dout), 32'(16'h1000 + 16'((j-1)/2)));
        check($sformatf("t3_en_j%0d", j), 32'(blob_dout_en), 32'd1);
        check($sformatf("t3_eop_j%0d", j), 32'(blob_dout_eop), 32'(j == 15));
      end else if (j >= 2) begin
        check($sformatf("t3_hold_j%0d", j), 32'(blob_dout), 32'(16'h1000 + 16'((j-2)/2)));
        check($sformatf("t3_en_j%0d", j), 32'(blob_dout_en), 32'd0);
      end
      tick();
    end
    blob_dout_rdy = 1'b1;
    check("t3_count_after", 32'(dut.r_count), 32'd0);

    // Test 4: fill with dout_rdy low, skid beats accepted, 5th beat overflows
    blob_dout_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      blob_din     = mk_beat(16'h2100 + 16'(k * 256));
      blob_din_en  = 1'b1;
      blob_din_eop = (k >= 3);
      check($sformatf("t4_din_rdy_k%0d", k), 32'(blob_din_rdy), 32'(k < 2));
      check($sformatf("t4_count_k%0d", k), 32'(dut.r_count), 32'(k));
      check($sformatf("t4_ovf_k%0d", k), 32'(overflow), 32'd0);
      tick();
    end
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    check("t4_ovf_set", 32'(overflow), 32'd1);
    check("t4_count_full", 32'(dut.r_count), 32'd4);
    check("t4_en_stalled", 32'(blob_dout_en), 32'd0);
    blob_dout_rdy = 1'b1;
    tick();
    for (int w = 0; w < 32; w++) begin
      exp_w = 16'h2100 + 16'((w/8) * 256 + w % 8);
      check($sformatf("t4_dout_w%0d", w), 32'(blob_dout), 32'(exp_w));
      check($sformatf("t4_en_w%0d", w), 32'(blob_dout_en), 32'd1);
      check($sformatf("t4_eop_w%0d", w), 32'(blob_dout_eop), 32'(w == 31));
      tick();
    end
    check("t4_en_after", 32'(blob_dout_en), 32'd0);
    check("t4_count_after", 32'(dut.r_count), 32'd0);
    check("t4_din_rdy_after", 32'(blob_din_rdy), 32'd1);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);

    // Test 5: reset during lane 3 with 2 beats queued
    for (int k = 0; k < 5; k++) begin
      blob_din     = mk_beat(16'h3100 + 16'(k * 256));
      blob_din_en  = (k < 3);
      blob_din_eop = (k < 3);
      tick();
    end
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    check("t5_lane3", 32'(blob_dout), 32'h3103);
    check("t5_lane3_en", 32'(blob_dout_en), 32'd1);
    check("t5_queued", 32'(dut.r_count), 32'd2);
    rst = 1'b1;
    #1;
    check("t5_rst_dout", 32'(blob_dout), 32'd0);
    check("t5_rst_en", 32'(blob_dout_en), 32'd0);
    check("t5_rst_eop", 32'(blob_dout_eop), 32'd0);
    check("t5_rst_ovf", 32'(overflow), 32'd0);
    check("t5_rst_din_rdy", 32'(blob_din_rdy), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("t5_post_en", 32'(blob_dout_en), 32'd0);
    check("t5_post_count", 32'(dut.r_count), 32'd0);
    single_beat("t5_fresh", 16'h4001, 1'b1);

    // Test 6: eop without en is ignored
    blob_din     = mk_beat(16'hdead);
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b1;
    tick();
    check("t6_count_stray", 32'(dut.r_count), 32'd0);
    single_beat("t6", 16'h5001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
